bus_mux_param: RTL and testbench

BUS_MUX_PARAM -- requirements
Module: bus_mux_param

---
 rtl/bus_mux_param.sv | 114 +++++++++++
 tb/tb_bus_mux_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_param.sv
// bus_mux_param: registered N_SRC-to-1 bus multiplexer.
// Exactly one enabled source loads the bus. When several sources are enabled,
// the lowest index wins and a conflict pulse plus a sticky flag are raised.
// Define BUS_MUX_CONFLICT_COUNT_EN to add a saturating 8-bit conflict counter
// on port conflict_count.
module bus_mux_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_SRC  = 24,
  localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_out_en,
  input  logic                    conflict_clr,
  output logic [DATA_W-1:0]       bus_out,
  output logic [SEL_W-1:0]        bus_sel,
  output logic                    bus_valid,
  output logic                    conflict,
  output logic                    conflict_sticky
`ifdef BUS_MUX_CONFLICT_COUNT_EN
  ,
  output logic [7:0]              conflict_count
`endif
);

  logic              hit;
  logic              multi;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;

  logic [DATA_W-1:0] bus_d,      bus_q;
  logic [SEL_W-1:0]  sel_d,      sel_q;
  logic              valid_d,    valid_q;
  logic              conflict_d, conflict_q;
  logic              sticky_d,   sticky_q;

  // Fixed-priority select: the first enabled source scanning upward wins.
  always_comb begin
    hit      = 1'b0;
    win_sel  = '0;
    win_data = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_out_en[i] && !hit) begin
        hit      = 1'b1;
        win_sel  = SEL_W'(i);
        win_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // More than one enable bit set: clearing the lowest set bit leaves a residue.
  always_comb begin
    multi = |(src_out_en & (src_out_en - N_SRC'(1)));
  end

  // Next-state: load on any enable, hold bus/select when idle; set beats clear.
  always_comb begin
    bus_d      = hit ? win_data : bus_q;
    sel_d      = hit ? win_sel  : sel_q;
    valid_d    = hit;
    conflict_d = multi;
    sticky_d   = multi | (sticky_q & ~conflict_clr);
  end

  // Output registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      bus_q      <= bus_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus_out         = bus_q;
  assign bus_sel         = sel_q;
  assign bus_valid       = valid_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;

`ifdef BUS_MUX_CONFLICT_COUNT_EN
  logic [7:0] count_d, count_q;

  // Saturating conflict counter; a clear in a conflict cycle restarts at 1.
  always_comb begin
    count_d = count_q;
    if (conflict_clr) begin
      count_d = multi ? 8'd1 : 8'd0;
    end else if (multi && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign conflict_count = count_q;
`endif

endmodule

// File: tb/tb_bus_mux_param.sv
// Self-checking bench for bus_mux_param: default (32x24) instance checked
// against a behavioural model, plus a 16x5 instance for the narrow case.
module tb_bus_mux_param;

  localparam int DW = 32;
  localparam int NS = 24;

  logic            clock = 1'b0;
  logic            clear = 1'b0;
  logic [NS*DW-1:0] src_data = '0;
  logic [NS-1:0]   src_out_en = '0;
  logic            conflict_clr = 1'b0;
  logic [DW-1:0]   bus_out;
  logic [4:0]      bus_sel;
  logic            bus_valid, conflict, conflict_sticky;
`ifdef BUS_MUX_CONFLICT_COUNT_EN
  logic [7:0]      conflict_count;
`endif

  logic [5*16-1:0] s_data = '0;
  logic [4:0]      s_en = '0;
  logic            s_clr = 1'b0;
  logic [15:0]     s_bus;
  logic [2:0]      s_sel;
  logic            s_valid, s_conf, s_sticky;
`ifdef BUS_MUX_CONFLICT_COUNT_EN
  logic [7:0]      s_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] m_bus;
  int            m_sel;
  logic          m_valid, m_conf, m_sticky;
  int            m_cnt;

  bus_mux_param #(.DATA_W(DW), .N_SRC(NS)) dut (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out_en(src_out_en),
    .conflict_clr(conflict_clr), .bus_out(bus_out), .bus_sel(bus_sel),
    .bus_valid(bus_valid), .conflict(conflict), .conflict_sticky(conflict_sticky)
`ifdef BUS_MUX_CONFLICT_COUNT_EN
    , .conflict_count(conflict_count)
`endif
  );

  bus_mux_param #(.DATA_W(16), .N_SRC(5)) dut_s (
    .clock(clock), .clear(clear), .src_data(s_data), .src_out_en(s_en),
    .conflict_clr(s_clr), .bus_out(s_bus), .bus_sel(s_sel),
    .bus_valid(s_valid), .conflict(s_conf), .conflict_sticky(s_sticky)
`ifdef BUS_MUX_CONFLICT_COUNT_EN
    , .conflict_count(s_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_bus = '0; m_sel = 0; m_valid = 1'b0; m_conf = 1'b0; m_sticky = 1'b0; m_cnt = 0;
  endtask

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic tick();
    int pop;
    int low;
    pop = 0;
    low = -1;
    @(posedge clock);
    for (int i = 0; i < NS; i++) begin
      if (src_out_en[i]) begin
        pop++;
        if (low < 0) low = i;
      end
    end
    if (pop > 0) begin
      m_bus = src_data[low*DW +: DW];
      m_sel = low;
    end
    m_valid  = (pop > 0);
    m_conf   = (pop >= 2);
    m_sticky = m_conf || (m_sticky && !conflict_clr);
    if (conflict_clr) m_cnt = m_conf ? 1 : 0;
    else if (m_conf && m_cnt < 255) m_cnt++;
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({bus_out, bus_sel, bus_valid, conflict, conflict_sticky} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got bus=%h sel=%0d v=%b c=%b s=%b, want all 0",
               bus_out, bus_sel, bus_valid, conflict, conflict_sticky);
    end
    clear = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    src_out_en = '0; src_out_en[5] = 1'b1;
    src_data[5*DW +: DW] = 32'hDEADBEEF;
    tick();
    n_vec++;
    if (bus_out !== 32'hDEADBEEF || bus_sel !== 5'd5 || bus_valid !== 1'b1 || conflict !== 1'b0) begin
      n_err++;
      $display("FAIL single_load: got bus=%h sel=%0d v=%b c=%b, want deadbeef 5 1 0",
               bus_out, bus_sel, bus_valid, conflict);
    end
  endtask

  task automatic test_idle();
    src_out_en = '0;
    src_data = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (bus_out !== 32'hDEADBEEF || bus_sel !== 5'd5 || bus_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_hold[%0d]: got bus=%h sel=%0d v=%b, want deadbeef 5 0",
                 k, bus_out, bus_sel, bus_valid);
      end
    end
  endtask

  task automatic test_conflict();
    src_out_en = '0; src_out_en[3] = 1'b1; src_out_en[20] = 1'b1;
    src_data[3*DW +: DW] = 32'h11;
    src_data[20*DW +: DW] = 32'h22;
    tick();
    n_vec++;
    if (bus_out !== 32'h11 || bus_sel !== 5'd3 || conflict !== 1'b1 || conflict_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_load: got bus=%h sel=%0d c=%b s=%b, want 11 3 1 1",
               bus_out, bus_sel, conflict, conflict_sticky);
    end
    src_out_en = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (conflict !== 1'b0 || conflict_sticky !== 1'b1) begin
        n_err++;
        $display("FAIL conflict_after[%0d]: got c=%b s=%b, want 0 1", k, conflict, conflict_sticky);
      end
    end
    conflict_clr = 1'b1;
    tick();
    n_vec++;
    if (conflict_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL sticky_clear: got %b, want 0", conflict_sticky);
    end
    // same-cycle clear and conflict: set wins
    src_out_en[1] = 1'b1; src_out_en[23] = 1'b1;
    tick();
    n_vec++;
    if (conflict_sticky !== 1'b1 || conflict !== 1'b1 || bus_sel !== 5'd1) begin
      n_err++;
      $display("FAIL sticky_set_wins: got s=%b c=%b sel=%0d, want 1 1 1",
               conflict_sticky, conflict, bus_sel);
    end
    conflict_clr = 1'b0;
    src_out_en = '0;
  endtask

  task automatic test_clear_mid();
    src_out_en = '0; src_out_en[7] = 1'b1;
    src_data[7*DW +: DW] = 32'h12345678;
    tick();
    n_vec++;
    if (bus_out !== 32'h12345678) begin
      n_err++;
      $display("FAIL clear_preload: got %h, want 12345678", bus_out);
    end
    #2 clear = 1'b0;
    #1;
    n_vec++;
    if ({bus_out, bus_sel, bus_valid, conflict, conflict_sticky} !== '0) begin
      n_err++;
      $display("FAIL clear_async: got bus=%h sel=%0d v=%b c=%b s=%b, want all 0",
               bus_out, bus_sel, bus_valid, conflict, conflict_sticky);
    end
    src_out_en[9] = 1'b1;
    @(posedge clock); #1;
    n_vec++;
    if (bus_out !== 32'h0 || bus_valid !== 1'b0 || conflict !== 1'b0) begin
      n_err++;
      $display("FAIL clear_held: got bus=%h v=%b c=%b, want 0 0 0", bus_out, bus_valid, conflict);
    end
    #2 clear = 1'b1;
    model_reset();
    src_out_en = '0; src_out_en[9] = 1'b1;
    src_data[9*DW +: DW] = 32'hCAFEF00D;
    tick();
    n_vec++;
    if (bus_out !== 32'hCAFEF00D || bus_sel !== 5'd9 || bus_valid !== 1'b1) begin
      n_err++;
      $display("FAIL clear_first_load: got bus=%h sel=%0d v=%b, want cafef00d 9 1",
               bus_out, bus_sel, bus_valid);
    end
    src_out_en = '0;
  endtask

  task automatic test_small();
    for (int i = 0; i < 5; i++) begin
      logic [15:0] w;
      w = (i == 4) ? 16'hA5A5 : 16'(16'h1000 + i * 16'h0111);
      s_en = '0; s_en[i] = 1'b1;
      s_data[i*16 +: 16] = w;
      @(posedge clock); #1;
      n_vec++;
      if (s_bus !== w || s_sel !== 3'(i) || s_valid !== 1'b1 || s_conf !== 1'b0) begin
        n_err++;
        $display("FAIL small_src%0d: got bus=%h sel=%0d v=%b c=%b, want %h %0d 1 0",
                 i, s_bus, s_sel, s_valid, s_conf, w, i);
      end
    end
    s_en = 5'b10110;
    @(posedge clock); #1;
    n_vec++;
    if (s_sel !== 3'd1 || s_conf !== 1'b1) begin
      n_err++;
      $display("FAIL small_conflict: got sel=%0d c=%b, want 1 1", s_sel, s_conf);
    end
    s_en = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int mode;
      for (int w = 0; w < NS; w++) src_data[w*DW +: DW] = $urandom;
      mode = $urandom_range(0, 3);
      src_out_en = '0;
      if (mode == 1) src_out_en[$urandom_range(0, NS-1)] = 1'b1;
      else if (mode == 2) begin
        src_out_en[$urandom_range(0, NS-1)] = 1'b1;
        src_out_en[$urandom_range(0, NS-1)] = 1'b1;
      end else if (mode == 3) src_out_en = NS'($urandom);
      conflict_clr = ($urandom_range(0, 7) == 0);
      tick();
      n_vec++;
      if (bus_out !== m_bus || bus_sel !== 5'(m_sel) || bus_valid !== m_valid ||
          conflict !== m_conf || conflict_sticky !== m_sticky) begin
        n_err++;
        $display("FAIL random[%0d]: got bus=%h sel=%0d v=%b c=%b s=%b, want %h %0d %b %b %b",
                 n, bus_out, bus_sel, bus_valid, conflict, conflict_sticky,
                 m_bus, m_sel, m_valid, m_conf, m_sticky);
      end
`ifdef BUS_MUX_CONFLICT_COUNT_EN
      n_vec++;
      if (conflict_count !== 8'(m_cnt)) begin
        n_err++;
        $display("FAIL random_count[%0d]: got %0d, want %0d", n, conflict_count, m_cnt);
      end
`endif
    end
    conflict_clr = 1'b0;
    src_out_en = '0;
  endtask

`ifdef BUS_MUX_CONFLICT_COUNT_EN
  task automatic test_count();
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
    src_out_en = '0; src_out_en[0] = 1'b1; src_out_en[NS-1] = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254 || k == 255 || k == 300) begin
        n_vec++;
        if (conflict_count !== 8'(m_cnt) || m_cnt != ((k > 255) ? 255 : k)) begin
          n_err++;
          $display("FAIL count_sat[%0d]: got %0d, want %0d", k, conflict_count,
                   (k > 255) ? 255 : k);
        end
      end
    end
    src_out_en = '0;
    conflict_clr = 1'b1;
    tick();
    n_vec++;
    if (conflict_count !== 8'd0) begin
      n_err++;
      $display("FAIL count_clear: got %0d, want 0", conflict_count);
    end
    src_out_en[2] = 1'b1; src_out_en[4] = 1'b1;
    tick();
    n_vec++;
    if (conflict_count !== 8'd1) begin
      n_err++;
      $display("FAIL count_clear_conflict: got %0d, want 1", conflict_count);
    end
    conflict_clr = 1'b0;
    src_out_en = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_idle();
    test_conflict();
    test_clear_mid();
    test_small();
    test_random();
`ifdef BUS_MUX_CONFLICT_COUNT_EN
    test_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
